rom_addr_stepper: RTL and testbench

- Parametrised successor to the button-clocked 4-bit address counter that drives ROM address selection for the 7-segment data path.
- Runs on the system clock and takes the step button as a raw asynchronous input, which it synchronises and debounces internally.
- Adds up/down counting, an arbitrary modulus, wrap or saturate modes, a parallel load, and a wrap pulse.
- Output q feeds the ROM address port. at_start replaces the old ts flag.

---
 rtl/rom_disp_pkg.sv | 10 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/rom_addr_stepper.sv | 109 ++++++++++
 tb/tb_rom_addr_stepper.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_disp_pkg.sv
// Shared constants and types for the ROM / 7-segment display path.
package rom_disp_pkg;
  localparam int ADDR_WIDTH_DEFAULT = 4;
  localparam int DEBOUNCE_DEFAULT   = 500000;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;
endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-count debouncer, and a
// registered one-clock pulse on each debounced press (0->1 only).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic          s1, s2;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      level_q <= level;
      pulse   <= level & ~level_q;
      // Any clock where the synchronised input agrees restarts the count.
      if (s2 == level)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/rom_addr_stepper.sv
// ROM address stepper: debounced button steps q up/down modulo MODULUS, with
// wrap or saturate, clamped parallel load and a wrap pulse. Optional auto-step
// enabled by ROM_ADDR_STEPPER_AUTO_STEP_EN.
module rom_addr_stepper
  import rom_disp_pkg::*;
#(
  parameter int WIDTH           = ADDR_WIDTH_DEFAULT,
  parameter int MODULUS         = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
`ifdef ROM_ADDR_STEPPER_AUTO_STEP_EN
  parameter int AUTO_PERIOD     = 50000000,
`endif
  parameter int WRAP            = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             step_btn,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef ROM_ADDR_STEPPER_AUTO_STEP_EN
  input  logic             auto,
`endif
  output logic [WIDTH-1:0] q,
  output logic             at_start,
  output logic             wrap
);
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("rom_addr_stepper: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic             btn_step, step;
  logic [WIDTH-1:0] q_n, load_c;
  logic             at_start_n, wrap_n;
  dir_e             d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk  (clk),
    .clr  (clr),
    .btn  (step_btn),
    .pulse(btn_step)
  );

`ifdef ROM_ADDR_STEPPER_AUTO_STEP_EN
  localparam int PW = $clog2(AUTO_PERIOD + 1);
  logic [PW-1:0] pcnt;
  logic          tick;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      pcnt <= '0;
    else if (!auto || pcnt == PW'(AUTO_PERIOD - 1))
      pcnt <= '0;
    else
      pcnt <= pcnt + 1'b1;
  end

  assign tick = auto && (pcnt == PW'(AUTO_PERIOD - 1));
  // Button presses are ignored entirely while auto-stepping.
  assign step = auto ? tick : btn_step;
`else
  assign step = btn_step;
`endif

  assign d      = dir_e'(dir);
  assign load_c = ({1'b0, load_val} >= (WIDTH+1)'(MODULUS)) ? MAX : load_val;

  always_comb begin
    q_n        = q;
    at_start_n = at_start;
    wrap_n     = 1'b0;
    if (load) begin
      q_n        = load_c;
      at_start_n = 1'b0;
    end else if (step) begin
      // A saturated hold still counts as an accepted step.
      at_start_n = 1'b0;
      if (d == DIR_UP) begin
        if (q < MAX)
          q_n = q + 1'b1;
        else if (WRAP != 0) begin
          q_n    = '0;
          wrap_n = 1'b1;
        end
      end else begin
        if (q != '0)
          q_n = q - 1'b1;
        else if (WRAP != 0) begin
          q_n    = MAX;
          wrap_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q        <= '0;
      at_start <= 1'b1;
      wrap     <= 1'b0;
    end else begin
      q        <= q_n;
      at_start <= at_start_n;
      wrap     <= wrap_n;
    end
  end
endmodule

// File: tb/tb_rom_addr_stepper.sv
// Directed bench for rom_addr_stepper: three instances (mod-16 wrap, mod-10
// wrap, mod-10 saturate) share stimulus; DEBOUNCE_CYCLES=4 throughout.
module tb_rom_addr_stepper;
  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         clr, step_btn, dir, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q_a, q_b, q_c;
  logic         st_a, st_b, st_c, wr_a, wr_b, wr_c;
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  rom_addr_stepper #(.WIDTH(W), .MODULUS(16), .DEBOUNCE_CYCLES(D), .WRAP(1)) u_a (
    .clk(clk), .clr(clr), .step_btn(step_btn), .dir(dir), .load(load),
    .load_val(load_val), .q(q_a), .at_start(st_a), .wrap(wr_a));
  rom_addr_stepper #(.WIDTH(W), .MODULUS(10), .DEBOUNCE_CYCLES(D), .WRAP(1)) u_b (
    .clk(clk), .clr(clr), .step_btn(step_btn), .dir(dir), .load(load),
    .load_val(load_val), .q(q_b), .at_start(st_b), .wrap(wr_b));
  rom_addr_stepper #(.WIDTH(W), .MODULUS(10), .DEBOUNCE_CYCLES(D), .WRAP(0)) u_c (
    .clk(clk), .clr(clr), .step_btn(step_btn), .dir(dir), .load(load),
    .load_val(load_val), .q(q_c), .at_start(st_c), .wrap(wr_c));

  // Stimulus helpers only; every check is inline in the test tasks.
  task press_hold(input int n);
    step_btn = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task release_btn;
    step_btn = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task test_reset;
    #1;
    n_vec++;
    if ({q_a, st_a, wr_a} !== 6'b0000_1_0) begin
      n_err++; $display("FAIL reset_a: got %b want 000010", {q_a, st_a, wr_a});
    end
    n_vec++;
    if ({q_b, st_b, wr_b, q_c, st_c, wr_c} !== 12'b0000_1_0_0000_1_0) begin
      n_err++; $display("FAIL reset_bc: got %b", {q_b, st_b, wr_b, q_c, st_c, wr_c});
    end
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({q_a, st_a, wr_a} !== 6'b0000_1_0) begin
      n_err++; $display("FAIL reset_idle: got %b want 000010", {q_a, st_a, wr_a});
    end
  endtask

  // Button first sampled at edge i=1; q must move on i=8 and never again.
  task test_clean_press;
    logic [5:0] exp;
    dir = 1'b1;
    step_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      exp = (i >= 8) ? {4'd1, 1'b0, 1'b0} : {4'd0, 1'b1, 1'b0};
      n_vec++;
      if ({q_a, st_a, wr_a} !== exp) begin
        n_err++; $display("FAIL clean_press edge %0d: got %b want %b", i, {q_a, st_a, wr_a}, exp);
      end
    end
    release_btn();
  endtask

  task test_bounce;
    logic [W-1:0] exp;
    for (int s = 0; s < 6; s++) begin
      step_btn = (s % 2 == 0);
      repeat (2) begin
        @(posedge clk); #1;
        n_vec++;
        if (q_a !== 4'd1) begin
          n_err++; $display("FAIL bounce_hold: got %0d want 1", q_a);
        end
      end
    end
    step_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp = (i >= 8) ? 4'd2 : 4'd1;
      n_vec++;
      if (q_a !== exp) begin
        n_err++; $display("FAIL bounce_settle edge %0d: got %0d want %0d", i, q_a, exp);
      end
    end
    release_btn();
  endtask

  task test_wrap;
    do_load(4'd9);
    n_vec++;
    if ({q_b, st_b, wr_b} !== {4'd9, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL wrap_load: got %b want 100100", {q_b, st_b, wr_b});
    end
    dir = 1'b1;
    press_hold(7);
    n_vec++;
    if ({q_b, wr_b} !== {4'd9, 1'b0}) begin
      n_err++; $display("FAIL wrap_up_pre: got %b want 10010", {q_b, wr_b});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({q_b, wr_b} !== {4'd0, 1'b1}) begin
      n_err++; $display("FAIL wrap_up: got %b want 00001", {q_b, wr_b});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({q_b, wr_b} !== {4'd0, 1'b0}) begin
      n_err++; $display("FAIL wrap_up_pulse_end: got %b want 00000", {q_b, wr_b});
    end
    release_btn();
    dir = 1'b0;
    press_hold(8);
    n_vec++;
    if ({q_b, wr_b} !== {4'd9, 1'b1}) begin
      n_err++; $display("FAIL wrap_down: got %b want 10011", {q_b, wr_b});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({q_b, wr_b} !== {4'd9, 1'b0}) begin
      n_err++; $display("FAIL wrap_down_pulse_end: got %b want 10010", {q_b, wr_b});
    end
    release_btn();
  endtask

  task test_saturate;
    do_load(4'd9);
    dir = 1'b1;
    press_hold(8);
    n_vec++;
    if ({q_c, wr_c} !== {4'd9, 1'b0}) begin
      n_err++; $display("FAIL sat_up: got %b want 10010", {q_c, wr_c});
    end
    n_vec++;
    if ({q_b, wr_b} !== {4'd0, 1'b1}) begin
      n_err++; $display("FAIL sat_up_ref_wrap: got %b want 00001", {q_b, wr_b});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({q_c, wr_c} !== {4'd9, 1'b0}) begin
      n_err++; $display("FAIL sat_up_hold: got %b want 10010", {q_c, wr_c});
    end
    release_btn();
    do_load(4'd0);
    dir = 1'b0;
    press_hold(8);
    n_vec++;
    if ({q_c, wr_c} !== {4'd0, 1'b0}) begin
      n_err++; $display("FAIL sat_down: got %b want 00000", {q_c, wr_c});
    end
    n_vec++;
    if ({q_b, wr_b} !== {4'd9, 1'b1}) begin
      n_err++; $display("FAIL sat_down_ref_wrap: got %b want 10011", {q_b, wr_b});
    end
    release_btn();
  endtask

  // Load lands on the same edge the step pulse is consumed (edge 8).
  task test_load_priority;
    do_load(4'd3);
    dir = 1'b1;
    press_hold(7);
    load = 1'b1; load_val = 4'd12;
    @(posedge clk); #1;
    load = 1'b0;
    n_vec++;
    if ({q_a, q_b, q_c, wr_b} !== {4'd12, 4'd9, 4'd9, 1'b0}) begin
      n_err++; $display("FAIL load_clamp: got a=%0d b=%0d c=%0d wrap=%b want 12 9 9 0",
                        q_a, q_b, q_c, wr_b);
    end
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if ({q_a, q_b} !== {4'd12, 4'd9}) begin
      n_err++; $display("FAIL load_step_dropped: got a=%0d b=%0d want 12 9", q_a, q_b);
    end
    release_btn();
    press_hold(8);
    n_vec++;
    if ({q_b, wr_b, q_a} !== {4'd0, 1'b1, 4'd13}) begin
      n_err++; $display("FAIL load_next_press: got b=%0d wrap=%b a=%0d want 0 1 13",
                        q_b, wr_b, q_a);
    end
    release_btn();
  endtask

  task test_clr_mid_debounce;
    logic [5:0] exp;
    dir = 1'b1;
    press_hold(4);
    clr = 1'b1;
    #1;
    n_vec++;
    if ({q_a, st_a, wr_a} !== 6'b0000_1_0) begin
      n_err++; $display("FAIL clr_async: got %b want 000010", {q_a, st_a, wr_a});
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({q_a, st_a, wr_a, q_b, q_c} !== {6'b0000_1_0, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL clr_held: got %b", {q_a, st_a, wr_a, q_b, q_c});
    end
    clr = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp = (i >= 8) ? {4'd1, 1'b0, 1'b0} : {4'd0, 1'b1, 1'b0};
      n_vec++;
      if ({q_a, st_a, wr_a} !== exp) begin
        n_err++; $display("FAIL clr_release edge %0d: got %b want %b", i, {q_a, st_a, wr_a}, exp);
      end
    end
    release_btn();
  endtask

  initial begin
    clr = 1'b1; step_btn = 1'b0; dir = 1'b1; load = 1'b0; load_val = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_saturate();
    test_load_priority();
    test_clr_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
